// File: rtl/max6682_mean_n_pkg.sv
// Shared types and constants for the MAX6682 mean sampler.
// Defaults here are the parameter defaults of max6682_mean_n.
package max6682_mean_n_pkg;

    typedef enum logic [2:0] {
        ST_DISABLED,
        ST_IDLE,
        ST_XFER,
        ST_PAUSE,
        ST_COMPARE,
        ST_NOTIFY
    } state_e;

    typedef enum logic [2:0] {
        XS_IDLE,
        XS_WRITE,
        XS_WAIT,
        XS_READ,
        XS_DONE
    } xfer_state_e;

    localparam int SPI_FRAME_BYTES    = 2;
    localparam int MEAN_LOG2_DEF      = 2;
    localparam int VALUE_WIDTH_DEF    = 11;
    localparam int VALUE_SHIFT_DEF    = 5;
    localparam int TIMEOUT_CYCLES_DEF = 1024;

endpackage

// File: rtl/max6682_spi_xfer.sv
// One 2-byte sensor frame: Write x2, wait for SPI_Transmission fall, ReadNext x2, frame_vld pulse.
// Latency: frame_vld one cycle after the second ReadNext; CS_n high from that cycle on.
// Backpressure: waits on transmission end, aborted after TIMEOUT_CYCLES with MAX6682_MEAN_N_TIMEOUT_EN.
module max6682_spi_xfer
    import max6682_mean_n_pkg::*;
`ifdef MAX6682_MEAN_N_TIMEOUT_EN
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
)
`endif
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        spi_trans,
    input  logic [7:0]  spi_rx_dat,
    output logic        cs_n,
    output logic        spi_write,
    output logic        spi_read_next,
    output logic        frame_vld,
`ifdef MAX6682_MEAN_N_TIMEOUT_EN
    output logic        timeout,
`endif
    output logic [15:0] frame_dat
);

    localparam int BEAT_W = (SPI_FRAME_BYTES > 1) ? $clog2(SPI_FRAME_BYTES) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(SPI_FRAME_BYTES - 1);

    xfer_state_e       state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [15:0]       frame_q, frame_d;
    logic              trans_q;
    logic              trans_fall;

`ifdef MAX6682_MEAN_N_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_q, wd_d;
`endif

    assign trans_fall = trans_q & ~spi_trans;
    assign frame_dat  = frame_q;

    always_comb begin
        state_d       = state_q;
        beat_d        = beat_q;
        frame_d       = frame_q;
        cs_n          = 1'b1;
        spi_write     = 1'b0;
        spi_read_next = 1'b0;
        frame_vld     = 1'b0;
`ifdef MAX6682_MEAN_N_TIMEOUT_EN
        wd_d          = wd_q;
        timeout       = 1'b0;
`endif
        case (state_q)
            XS_IDLE: begin
                beat_d = '0;
                if (start) state_d = XS_WRITE;
            end
            XS_WRITE: begin
                cs_n      = 1'b0;
                spi_write = 1'b1;
                if (beat_q == LAST_BEAT) begin
                    beat_d  = '0;
                    state_d = XS_WAIT;
`ifdef MAX6682_MEAN_N_TIMEOUT_EN
                    wd_d    = '0;
`endif
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
            XS_WAIT: begin
                cs_n = 1'b0;
                if (trans_fall) begin
                    state_d = XS_READ;
                end
`ifdef MAX6682_MEAN_N_TIMEOUT_EN
                // wd_q counts completed wait cycles, so the abort lands on cycle TIMEOUT_CYCLES+1
                else if (wd_q == WD_W'(TIMEOUT_CYCLES)) begin
                    timeout = 1'b1;
                    state_d = XS_IDLE;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
`endif
            end
            XS_READ: begin
                cs_n          = 1'b0;
                spi_read_next = 1'b1;
                frame_d       = {frame_q[7:0], spi_rx_dat};
                if (beat_q == LAST_BEAT) begin
                    beat_d  = '0;
                    state_d = XS_DONE;
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
            XS_DONE: begin
                frame_vld = 1'b1;
                state_d   = XS_IDLE;
            end
            default: state_d = XS_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= XS_IDLE;
            beat_q  <= '0;
            frame_q <= '0;
            trans_q <= 1'b0;
`ifdef MAX6682_MEAN_N_TIMEOUT_EN
            wd_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            frame_q <= frame_d;
            trans_q <= spi_trans;
`ifdef MAX6682_MEAN_N_TIMEOUT_EN
            wd_q    <= wd_d;
`endif
        end
    end

endmodule

// File: rtl/max6682_mean_n.sv
// MAX6682 sampler: periodic bursts of 2**MEAN_LOG2 frames, mean reported when it moves past Threshold_i.
// Latency: Compare the cycle after the last frame, Notify (CpuIntr_o) the next; SensorValue_o updates after Notify.
// Backpressure: none; SPI wait unbounded, or bounded by TIMEOUT_CYCLES with MAX6682_MEAN_N_TIMEOUT_EN (adds Error_o).
module max6682_mean_n
    import max6682_mean_n_pkg::*;
#(
    parameter int MEAN_LOG2      = MEAN_LOG2_DEF,
    parameter int VALUE_WIDTH    = VALUE_WIDTH_DEF,
    parameter int VALUE_SHIFT    = VALUE_SHIFT_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic        Clk_i,
    input  logic        Reset_n_i,
    input  logic        Enable_i,
    output logic        CpuIntr_o,
    output logic        MAX6682CS_n_o,
    output logic        SPI_Write_o,
    output logic        SPI_ReadNext_o,
    output logic [7:0]  SPI_Data_o,
    input  logic [7:0]  SPI_Data_i,
    input  logic        SPI_FIFOFull_i,
    input  logic        SPI_FIFOEmpty_i,
    input  logic        SPI_Transmission_i,
    output logic        SPI_CPOL_o,
    output logic        SPI_CPHA_o,
    output logic        SPI_LSBFE_o,
    input  logic [15:0] PeriodCounterPresetH_i,
    input  logic [15:0] PeriodCounterPresetL_i,
    input  logic [15:0] PauseCounterPreset_i,
    input  logic [15:0] Threshold_i,
    output logic [15:0] SensorValue_o,
`ifdef MAX6682_MEAN_N_TIMEOUT_EN
    output logic        Error_o,
`endif
    output logic        Busy_o
);

    localparam int CNT_W = MEAN_LOG2 + 1;
    localparam int ACC_W = VALUE_WIDTH + MEAN_LOG2;
    localparam logic [CNT_W-1:0] SAMPLES = CNT_W'(1 << MEAN_LOG2);

    state_e                 state_q, state_d;
    logic [31:0]            period_q, period_d;
    logic [15:0]            pause_q, pause_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;
    logic [ACC_W-1:0]       acc_q, acc_d;
    logic [15:0]            value_q, value_d;
    logic [VALUE_WIDTH-1:0] sample, mean;
    logic [15:0]            mean_ext, diff;
    logic                   xfer_start, xfer_vld;
    logic [15:0]            xfer_frame;
    logic                   unused_spi_status;

`ifdef MAX6682_MEAN_N_TIMEOUT_EN
    logic xfer_timeout;
    assign Error_o = xfer_timeout;
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

    // FIFO occupancy is implied by the fixed 2-byte frame protocol
    assign unused_spi_status = SPI_FIFOFull_i ^ SPI_FIFOEmpty_i;

    max6682_spi_xfer
`ifdef MAX6682_MEAN_N_TIMEOUT_EN
    #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES))
`endif
    u_xfer (
        .clk           (Clk_i),
        .rst_n         (Reset_n_i),
        .start         (xfer_start),
        .spi_trans     (SPI_Transmission_i),
        .spi_rx_dat    (SPI_Data_i),
        .cs_n          (MAX6682CS_n_o),
        .spi_write     (SPI_Write_o),
        .spi_read_next (SPI_ReadNext_o),
        .frame_vld     (xfer_vld),
`ifdef MAX6682_MEAN_N_TIMEOUT_EN
        .timeout       (xfer_timeout),
`endif
        .frame_dat     (xfer_frame)
    );

    assign sample   = VALUE_WIDTH'(xfer_frame >> VALUE_SHIFT);
    assign mean     = VALUE_WIDTH'(acc_q >> MEAN_LOG2);
    assign mean_ext = 16'(mean);
    assign diff     = (mean_ext >= value_q) ? (mean_ext - value_q) : (value_q - mean_ext);
    assign cnt_inc  = cnt_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        period_d   = period_q;
        pause_d    = pause_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        value_d    = value_q;
        xfer_start = 1'b0;
        case (state_q)
            ST_DISABLED: begin
                period_d = {PeriodCounterPresetH_i, PeriodCounterPresetL_i};
                if (Enable_i) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (!Enable_i) begin
                    state_d = ST_DISABLED;
                end else if (period_q == 32'd0) begin
                    state_d    = ST_XFER;
                    period_d   = {PeriodCounterPresetH_i, PeriodCounterPresetL_i};
                    cnt_d      = '0;
                    xfer_start = 1'b1;
                end else begin
                    period_d = period_q - 32'd1;
                end
            end
            ST_XFER: begin
`ifdef MAX6682_MEAN_N_TIMEOUT_EN
                if (xfer_timeout) begin
                    state_d = ST_IDLE;
                end else
`endif
                if (xfer_vld) begin
                    acc_d = (cnt_q == '0) ? ACC_W'(sample) : acc_q + ACC_W'(sample);
                    cnt_d = cnt_inc;
                    if (!Enable_i) begin
                        state_d = ST_DISABLED;
                    end else if (cnt_inc < SAMPLES) begin
                        state_d = ST_PAUSE;
                        pause_d = PauseCounterPreset_i;
                    end else begin
                        state_d = ST_COMPARE;
                    end
                end
            end
            ST_PAUSE: begin
                if (!Enable_i) begin
                    state_d = ST_DISABLED;
                end else if (pause_q == 16'd0) begin
                    state_d    = ST_XFER;
                    xfer_start = 1'b1;
                end else begin
                    pause_d = pause_q - 16'd1;
                end
            end
            ST_COMPARE: begin
                state_d = (diff > Threshold_i) ? ST_NOTIFY : ST_IDLE;
            end
            ST_NOTIFY: begin
                value_d = mean_ext;
                state_d = ST_IDLE;
            end
            default: state_d = ST_DISABLED;
        endcase
    end

    always_ff @(posedge Clk_i) begin
        if (!Reset_n_i) begin
            state_q  <= ST_DISABLED;
            period_q <= '0;
            pause_q  <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            value_q  <= '0;
        end else begin
            state_q  <= state_d;
            period_q <= period_d;
            pause_q  <= pause_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            value_q  <= value_d;
        end
    end

    assign CpuIntr_o     = (state_q == ST_NOTIFY);
    assign Busy_o        = (state_q == ST_XFER) || (state_q == ST_PAUSE) ||
                           (state_q == ST_COMPARE) || (state_q == ST_NOTIFY);
    assign SensorValue_o = value_q;
    assign SPI_Data_o    = 8'h00;
    assign SPI_CPOL_o    = 1'b0;
    assign SPI_CPHA_o    = 1'b0;
    assign SPI_LSBFE_o   = 1'b0;

endmodule
